rng_xorshift_stream: RTL and testbench
======================================

RNG_XORSHIFT_STREAM -- requirements
Module: rng_xorshift_stream

Interface
REQ-001 Parameter OUT_W, default 8: output chunk width in bits; legal values 8, 16, 32.
REQ-002 Parameter SEED, default 32'h8E20A6E5: reset seed and fallback seed for the generator.
REQ-003 Parameter CNT_W, default 16: width of the generated-word counter.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 seed_we  input  1  load seed_in into the generator this cycle.
REQ-007 seed_in  input  32  new seed value.
REQ-008 rnd_ready  input  1  consumer accepts rnd_out this cycle.
REQ-009 rnd_valid  output  1  rnd_out holds a fresh random chunk.
REQ-010 rnd_out  output  OUT_W  random chunk.
REQ-011 word_cnt  output  CNT_W  number of 32-bit words generated since reset or reseed; saturating.

Function
REQ-012 Generator state s SHALL be 32 bits, with next value xs(s) computed combinationally: t=s^(s<<13); t=t^(t>>17); t=t^(t<<5); all shifts logical and truncated to 32 bits.
REQ-013 The block SHALL hold a 32-bit output buffer buf, a valid flag and a chunk index idx in 0..CHUNKS-1, where CHUNKS=32/OUT_W.
REQ-014 rnd_out SHALL equal buf[OUT_W-1:0]; words are emitted LSB chunk first.
REQ-015 Load: when the buffer is empty and seed_we=0, the block SHALL set s<=xs(s), buf<=xs(s), valid<=1, idx<=0 and increment word_cnt.
REQ-016 Transfer: a transfer occurs when rnd_valid=1 and rnd_ready=1 in the same cycle.
REQ-017 On a transfer with idx<CHUNKS-1, the block SHALL set buf<=buf>>OUT_W and idx<=idx+1.
REQ-018 On a transfer with idx=CHUNKS-1, the block SHALL perform a Load in the same cycle, so a continuously ready consumer receives one chunk per cycle with no bubbles.
REQ-019 Stall: while rnd_valid=1 and rnd_ready=0, rnd_out, idx and s SHALL hold stable.
REQ-020 Reseed: when seed_we=1, the block SHALL set s<=seed_in, or s<=SEED if seed_in==0 (xorshift zero lock-up guard).
REQ-021 Reseed SHALL also set valid<=0, idx<=0, buf<=0 and word_cnt<=0.
REQ-022 Reseed SHALL override a simultaneous Load or transfer; a chunk presented in that cycle counts as consumed.
REQ-023 After a reseed, rnd_valid SHALL be 0 for exactly one cycle, then rise carrying xs(new s) (REQ-015).
REQ-024 word_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 The generator SHALL advance only on a Load; no free-running advance while stalled.

Reset
REQ-026 While rst=1, the block SHALL set s<=SEED, buf<=0, valid<=0, idx<=0 and word_cnt<=0; outputs read rnd_valid=0, rnd_out=0, word_cnt=0.
REQ-027 rst SHALL take priority over seed_we and any transfer.
REQ-028 The first Load SHALL occur on the first clock edge with rst=0, so rnd_valid=1 one cycle after reset release.
REQ-029 Assertion of rst mid-word SHALL discard any remaining buffered chunks.

Structure
REQ-030 A shared package SHALL hold the default seed constant, the xorshift shift amounts (13, 17, 5) and a function implementing xs(); the masking core reuses that function.
REQ-031 A sub-module xorshift32_step (purely combinational, 32 in / 32 out) MAY hold xs(); the rest stays in one module.
REQ-032 The block SHALL reject an illegal OUT_W at elaboration.

Verification
REQ-033 Reset, then one cycle with rst=0 and rnd_ready=0 -> rnd_valid=1, rnd_out=xs(SEED)[7:0]; outputs stable for 10 stalled cycles.
REQ-034 OUT_W=8, seed_in=32'h1 with seed_we pulse, then rnd_ready=1 continuously -> after the one-cycle gap, bytes 21,20,04,00,01,06,08,04 on consecutive cycles (words 00042021, 04080601); word_cnt=2 after the second word loads.
REQ-035 OUT_W=32, seed 32'h1, rnd_ready=1 -> rnd_out 00042021 then 04080601 on back-to-back cycles, rnd_valid held at 1.
REQ-036 seed_we=1 with seed_in=0 -> next word equals xs(SEED), i.e. the same as after reset.
REQ-037 OUT_W=16, seed_we asserted at idx=1 together with a transfer -> remaining chunk dropped, rnd_valid=0 for one cycle, then xs(seed_in)[15:0].
REQ-038 CNT_W=2 with 5 words consumed -> word_cnt saturates at 3; rst mid-word -> rnd_valid=0 and word_cnt=0 during reset.

Source files
------------

// File: rtl/rng_xorshift_stream_pkg.sv
// Shared constants and the xorshift32 step for the random stream block.
// The shift triple (13, 17, 5) gives a full 2^32-1 period on nonzero state.
package rng_xorshift_stream_pkg;

  localparam logic [31:0] DEFAULT_SEED = 32'h8E20A6E5;
  localparam int unsigned XS_A = 13;
  localparam int unsigned XS_B = 17;
  localparam int unsigned XS_C = 5;

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << XS_A);
    t = t ^ (t >> XS_B);
    t = t ^ (t << XS_C);
    return t;
  endfunction

endpackage

// File: rtl/rng_xorshift_stream.sv
// Xorshift32 generator streamed out as OUT_W-bit chunks, LSB chunk first.
// The next word loads in the same cycle the last chunk leaves, so no bubbles.
module rng_xorshift_stream
  import rng_xorshift_stream_pkg::*;
#(
  parameter int          OUT_W = 8,
  parameter logic [31:0] SEED  = DEFAULT_SEED,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [31:0]      seed_in,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_out,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int         CHUNKS  = 32 / OUT_W;
  localparam logic [1:0] LAST    = 2'(CHUNKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    if (!(OUT_W == 8 || OUT_W == 16 || OUT_W == 32)) begin : g_bad_out_w
      $error("rng_xorshift_stream: OUT_W must be 8, 16 or 32");
    end
  endgenerate

  logic [31:0]      s_q, s_d;
  logic [31:0]      buf_q, buf_d;
  logic             valid_q, valid_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      nxt;
  logic             xfer;
  logic             load;

  assign nxt  = xs(s_q);
  assign xfer = valid_q & rnd_ready;
  assign load = !valid_q | (xfer & (idx_q == LAST));

  // Next-state: reseed beats load, load beats a plain chunk shift.
  always_comb begin
    s_d     = s_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (seed_we) begin
      s_d     = (seed_in == 32'd0) ? SEED : seed_in;
      buf_d   = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (load) begin
      s_d     = nxt;
      buf_d   = nxt;
      valid_d = 1'b1;
      idx_d   = '0;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (xfer) begin
      buf_d = buf_q >> OUT_W;
      idx_d = idx_q + 2'd1;
    end
  end

  // State registers with synchronous reset to the power-on seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= SEED;
      buf_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      s_q     <= s_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rnd_valid = valid_q;
  assign rnd_out   = buf_q[OUT_W-1:0];
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_rng_xorshift_stream.sv
// Scoreboard bench: three chunk widths share seed/reset stimulus,
// each with its own random ready; expected chunks come from a word model.
module tb_rng_xorshift_stream;

  localparam logic [31:0] SEED  = 32'h8E20A6E5;
  localparam int          WORDS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_we = 1'b0;
  logic [31:0] seed_in = 32'd0;
  logic        r8 = 1'b0, r16 = 1'b0, r32 = 1'b0;

  logic        v8, v16, v32;
  logic [7:0]  o8;
  logic [15:0] o16;
  logic [31:0] o32;
  logic [15:0] c8, c32;
  logic [1:0]  c16;

  int errors = 0;
  int checks = 0;

  logic        exp_v = 1'b0;
  logic [31:0] q [3][$];
  int          xf [3];

  always #5 clk = ~clk;

  rng_xorshift_stream #(.OUT_W(8), .SEED(SEED), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed_in(seed_in),
    .rnd_ready(r8), .rnd_valid(v8), .rnd_out(o8), .word_cnt(c8));

  rng_xorshift_stream #(.OUT_W(16), .SEED(SEED), .CNT_W(2)) dut16 (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed_in(seed_in),
    .rnd_ready(r16), .rnd_valid(v16), .rnd_out(o16), .word_cnt(c16));

  rng_xorshift_stream #(.OUT_W(32), .SEED(SEED), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed_in(seed_in),
    .rnd_ready(r32), .rnd_valid(v32), .rnd_out(o32), .word_cnt(c32));

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic check(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Valid is low exactly the cycle after reset or reseed, high otherwise.
  always @(posedge clk) exp_v <= !(rst || seed_we);

  // Monitor: compare presented chunks with the queue head, pop on transfer.
  always @(negedge clk) begin
    logic        v;
    logic        rdy;
    logic [31:0] o, c, exp_c, s, mask;
    int          ow, ch, cmax;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin v = v8;  o = 32'(o8);  c = 32'(c8);  rdy = r8;
                 ow = 8;  cmax = 65535; end
        1: begin v = v16; o = 32'(o16); c = 32'(c16); rdy = r16;
                 ow = 16; cmax = 3; end
        default: begin v = v32; o = o32; c = 32'(c32); rdy = r32;
                 ow = 32; cmax = 65535; end
      endcase
      ch = 32 / ow;
      check("valid", d, 32'(v), 32'(exp_v));
      if (exp_v) begin
        exp_c = 32'((1 + xf[d] / ch) > cmax ? cmax : (1 + xf[d] / ch));
        if (q[d].size() == 0) begin
          check("queue_nonempty", d, 32'd0, 32'd1);
        end else begin
          check("rnd_out", d, o, q[d][0]);
          if (v && rdy && !rst) begin
            void'(q[d].pop_front());
            xf[d]++;
          end
        end
      end else begin
        exp_c = 32'd0;
        check("rnd_out_idle", d, o, 32'd0);
      end
      check("word_cnt", d, c, exp_c);
      if (rst || seed_we) begin
        q[d].delete();
        xf[d] = 0;
        s = (rst || seed_in == 32'd0) ? SEED : seed_in;
        mask = 32'hFFFF_FFFF >> (32 - ow);
        for (int w = 0; w < WORDS; w++) begin
          s = ref_next(s);
          for (int k = 0; k < ch; k++)
            q[d].push_back((s >> (k * ow)) & mask);
        end
      end
    end
  end

  // mode: 0 all stalled, 1 all ready, 2 random per DUT
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: begin r8 = 1'b0; r16 = 1'b0; r32 = 1'b0; end
        1: begin r8 = 1'b1; r16 = 1'b1; r32 = 1'b1; end
        default: begin
          r8  = 1'($urandom_range(0, 1));
          r16 = 1'($urandom_range(0, 1));
          r32 = 1'($urandom_range(0, 1));
        end
      endcase
      @(posedge clk); #1;
    end
  endtask

  task automatic reseed(input logic [31:0] sd);
    seed_we = 1'b1;
    seed_in = sd;
    @(posedge clk); #1;
    seed_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run(12, 0);
    run(40, 2);
    reseed(32'h1);
    run(20, 1);
    reseed(32'h0);
    run(30, 2);
    reseed(32'h1);
    r8 = 1'b1; r16 = 1'b1; r32 = 1'b1;
    reseed(32'hDEAD_BEEF);
    run(2, 1);
    reseed(32'h1234_5678);
    run(25, 1);
    for (int seg = 0; seg < 6; seg++) begin
      reseed(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      run($urandom_range(3, 45), 2);
    end
    run(5, 1);
    rst = 1'b1;
    run(2, 2);
    rst = 1'b0;
    run(30, 2);
    run(20, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
